// File: rtl/uio_tx_pkg.sv
// Shared FSM encoding and pin-direction constants for the uio result transmitter.
package uio_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t SETUP    = 3'd1;
  localparam state_t REQ      = 3'd2;
  localparam state_t WAIT_LOW = 3'd3;
  localparam state_t TURN     = 3'd4;

  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational head read; push refused while full even if popping.
// Occupancy is registered; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uio_result_tx.sv
// Buffers core results and sends them over the uio pins with a four-phase req/ack handshake.
// First word drives the bus 2 cycles after push, req 1 cycle later; in_ready = !full.
module uio_result_tx
  import uio_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   tx_ack,
  output logic                   tx_req,
  output logic [WIDTH-1:0]       uio_out,
  output logic [WIDTH-1:0]       uio_oe,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic             fifo_full, fifo_empty, pop;
  logic [WIDTH-1:0] fifo_head;

  logic             ack_meta_q, ack_s_q;
  logic             head_avail_q, head_avail_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic             req_q, req_d;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign tx_req   = req_q;
  assign uio_oe   = oe_q;
  assign uio_out  = out_q;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    pop          = 1'b0;
    head_avail_d = !fifo_empty;
    case (state_q)
      // IDLE looks at occupancy one cycle late, giving the first word its extra cycle.
      IDLE: begin
        if (head_avail_q) begin
          out_d   = fifo_head;
          state_d = SETUP;
        end
      end
      SETUP: state_d = REQ;
      REQ: begin
        if (ack_s_q) begin
          pop     = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_s_q) begin
          if (!fifo_empty) begin
            out_d   = fifo_head;
            state_d = SETUP;
          end else begin
            state_d = TURN;
          end
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_d = (state_d == REQ);
    oe_d  = ((state_d == SETUP) || (state_d == REQ) || (state_d == WAIT_LOW))
            ? OE_DRIVE : OE_RELEASE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      head_avail_q <= 1'b0;
      state_q      <= IDLE;
      out_q        <= '0;
      oe_q         <= OE_RELEASE;
      req_q        <= 1'b0;
    end else begin
      ack_meta_q   <= tx_ack;
      ack_s_q      <= ack_meta_q;
      head_avail_q <= head_avail_d;
      state_q      <= state_d;
      out_q        <= out_d;
      oe_q         <= oe_d;
      req_q        <= req_d;
    end
  end

endmodule
